rsa_crypt_engine: RTL and testbench
===================================

# rsa_crypt_engine

Modular-exponentiation datapath that consumes the key produced by the key-generation stage (`n`, `e`, `d`, `done`). It computes `result = msg^exp mod n` for one message per request, using `e` to encrypt or `d` to decrypt. Exponentiation is right-to-left square-and-multiply over a shared sequential shift-add modular multiplier, so no `%` or wide multiplier is inferred. It sits directly downstream of key generation and feeds the chip's output register.

## Interface
- `W`, 7: width of `n`, `e`, `d`, `msg` and `result`; must match the key-generation output width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; one clock, and reset is synchronous active-high.
- `key_valid`  in  1  connected to key-generation `done`; a level signal.
- `n`  in  W  modulus.
- `e`  in  W  public exponent.
- `d`  in  W  private exponent.
- `start`  in  1  request strobe; accepted only when `ready`=1.
- `mode`  in  1  0 = encrypt (exponent `e`), 1 = decrypt (exponent `d`); sampled at accept.
- `msg`  in  W  plaintext or ciphertext; sampled at accept.
- `ready`  out  1  high in IDLE while `key_valid`=1.
- `busy`  out  1  high from the accept edge until the cycle `result_valid` pulses.
- `result`  out  W  last result; held until the next accept.
- `result_valid`  out  1  one-cycle pulse.
- `err`  out  1  one-cycle pulse when a request is rejected.

## Operation
- Reset values: `ready`=0, `busy`=0, `result`=0, `result_valid`=0, `err`=0. FSM goes to IDLE and the multiplier is cleared.
- At accept, `n`, the selected exponent, and `msg` are latched. Later changes to `n`/`e`/`d`/`key_valid` are ignored until the next accept.
- Rejects: `n`<2 or `msg`>=`n`. The block returns to IDLE the next cycle with an `err` pulse and `result`=0, and `result_valid` stays low.
- FSM states:
  - IDLE → LOAD on accept.
  - LOAD: set `acc`=1, `base`=`msg`, bit index i=0, or reject.
  - MUL: `acc`=`acc`·`base` mod `n`. Taken only if exp[i]=1.
  - SQR: `base`=`base`² mod `n`. Taken for i<W-1. Then i++, and go to MUL if the next bit is set, else SQR.
  - DONE: `result`=`acc`, pulse `result_valid`, go to IDLE.
- Squares are always performed through bit W-2, even after the remaining exponent is zero. Latency is therefore data-dependent only on popcount.
- `mod_mul` computes a·b mod n using interleaved shift-add, MSB of b first:
  - `r`=2r; if r>=n then r-=n.
  - if b[k] then r+=a; if r>=n then r-=n.
  - `r` is W+1 bits wide, and at most one subtract is applied per step.
  - Operands are always < n.
- exp=0 gives result 1.
- `start` while not ready is dropped. It is not queued.
- Reset mid-operation aborts the request; no `result_valid` is issued.

## Timing
- Each multiplier operation occupies exactly W+1 cycles: 1 issue cycle, then W iteration cycles, with the product valid on the last of them.
- Accepted request → `result_valid` pulse exactly `1 + (popcount(exp) + W - 1)·(W+1)` cycles after the accept edge. For W=7: 49 + 8·popcount.
- Reject → `err` pulse 1 cycle after accept. `ready` returns on the following cycle.
- `ready` is low from the accept edge through the `result_valid`/`err` cycle. It is high again the next cycle if `key_valid`=1.

## Structure
- Shared package `rsa_pkg`:
  - `W` constant (7).
  - mode encoding (`MODE_ENC`=0, `MODE_DEC`=1).
  - FSM state enum (IDLE, LOAD, MUL, SQR, DONE).
- One sub-module, `mod_mul`: ports `clk`, `reset`, `go`, `a`, `b`, `n`, `p`, `done`. It has its own W-step counter and is instantiated once.

## Test plan
- n=55, e=3, d=27, encrypt msg=2 → `result`=8, `result_valid` at cycle 65.
- Same key, decrypt msg=8 → `result`=2 at cycle 81. Round-trip every msg 0..54 and check decrypt(encrypt(m))=m.
- n=15, e=3: msg=7 → 13; msg=0 → 0; msg=14 → 14. Also with e=0 → 1 at cycle 49.
- Rejects: msg=55 with n=55 → `err` pulse at cycle 1, `result`=0, no `result_valid`. n=1 → `err`.
- Change `n`/`e` and drop `key_valid` mid-operation → result still matches the latched values. `start` while busy is ignored; no second `result_valid`.
- Assert `reset` at cycle 30 of a request → all outputs 0 next cycle. A following request completes correctly.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared constants for the RSA modular-exponentiation engine.
//   W        : operand width (n, e, d, msg, result)
//   IW       : width of the bit-index / iteration counters
//   MODE_*   : request mode encoding
//   S_*      : engine FSM state encoding
package rsa_pkg;

    localparam int W  = 7;
    localparam int IW = $clog2(W);

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_SQR  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/rsa_crypt_engine_mod_mul.sv
// Sequential shift-add modular multiplier: p = a*b mod n, MSB of b first.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   go         : issue strobe; a, b, n are latched on this edge
//   a, b, n    : operands (a, b < n)
//   p          : product, valid while done=1
//   done       : high on the last of the W iteration cycles
module mod_mul
    import rsa_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic [W-1:0] p,
    output logic         done
);

    logic [W-1:0]  a_q, b_q, n_q, r_q;
    logic [IW-1:0] cnt_q;
    logic          busy_q;
    logic [W:0]    dbl, acc;
    logic [W-1:0]  r_next;

    // One interleaved step; r stays below n so W+1 bits hold 2r and r+a.
    always_comb begin
        dbl = {r_q, 1'b0};
        if (dbl >= {1'b0, n_q}) dbl = dbl - {1'b0, n_q};
        acc = dbl;
        if (b_q[cnt_q]) acc = dbl + {1'b0, a_q};
        if (acc >= {1'b0, n_q}) acc = acc - {1'b0, n_q};
        r_next = acc[W-1:0];
    end

    assign p    = r_next;
    assign done = busy_q && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (go) begin
            a_q    <= a;
            b_q    <= b;
            n_q    <= n;
            r_q    <= '0;
            cnt_q  <= IW'(W - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            r_q <= r_next;
            if (cnt_q == '0) busy_q <= 1'b0;
            else             cnt_q  <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/rsa_crypt_engine.sv
// RSA modular exponentiation: result = msg^exp mod n, exp = e (encrypt) or d (decrypt).
// Right-to-left square-and-multiply over one shared mod_mul instance.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   key_valid        : key-generation done level
//   n, e, d          : modulus and exponents
//   start, mode, msg : request strobe, 0=encrypt/1=decrypt, message (sampled at accept)
//   ready, busy      : handshake status
//   result           : last result, held until next accept
//   result_valid     : one-cycle completion pulse
//   err              : one-cycle reject pulse (n<2 or msg>=n)
module rsa_crypt_engine
    import rsa_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    input  logic [W-1:0] n,
    input  logic [W-1:0] e,
    input  logic [W-1:0] d,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] msg,
    output logic         ready,
    output logic         busy,
    output logic [W-1:0] result,
    output logic         result_valid,
    output logic         err
);

    localparam logic [IW-1:0] LAST = IW'(W - 1);

    logic [2:0]    state_q;
    logic [W-1:0]  n_q, exp_q, acc_q, base_q, result_q;
    logic [IW-1:0] idx_q, nxt_idx;
    logic          issued_q, rej_q, rdy_en_q;
    logic          accept, mul_go, mul_done;
    logic [W-1:0]  mul_a, mul_p;

    // rdy_en_q keeps ready low in the cycle right after reset.
    assign ready        = (state_q == S_IDLE) && key_valid && rdy_en_q;
    assign busy         = (state_q == S_LOAD) || (state_q == S_MUL) || (state_q == S_SQR);
    assign result       = result_q;
    assign result_valid = (state_q == S_DONE) && !rej_q;
    assign err          = (state_q == S_DONE) && rej_q;
    assign accept       = ready && start;

    // First cycle of MUL/SQR issues the multiplier; done arrives W cycles later.
    assign mul_go  = ((state_q == S_MUL) || (state_q == S_SQR)) && !issued_q;
    assign mul_a   = (state_q == S_MUL) ? acc_q : base_q;
    assign nxt_idx = idx_q + 1'b1;

    mod_mul u_mod_mul (
        .clk   (clk),
        .reset (reset),
        .go    (mul_go),
        .a     (mul_a),
        .b     (base_q),
        .n     (n_q),
        .p     (mul_p),
        .done  (mul_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            exp_q    <= '0;
            acc_q    <= '0;
            base_q   <= '0;
            result_q <= '0;
            idx_q    <= '0;
            issued_q <= 1'b0;
            rej_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        n_q     <= n;
                        exp_q   <= (mode == MODE_ENC) ? e : d;
                        base_q  <= msg;
                        rej_q   <= 1'b0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if ((n_q < W'(2)) || (base_q >= n_q)) begin
                        rej_q    <= 1'b1;
                        result_q <= '0;
                        state_q  <= S_DONE;
                    end else begin
                        acc_q   <= W'(1);
                        idx_q   <= '0;
                        state_q <= exp_q[0] ? S_MUL : S_SQR;
                    end
                end
                S_MUL: begin
                    if (mul_go) begin
                        issued_q <= 1'b1;
                    end else if (mul_done) begin
                        issued_q <= 1'b0;
                        acc_q    <= mul_p;
                        if (idx_q == LAST) begin
                            result_q <= mul_p;
                            state_q  <= S_DONE;
                        end else begin
                            state_q <= S_SQR;
                        end
                    end
                end
                S_SQR: begin
                    if (mul_go) begin
                        issued_q <= 1'b1;
                    end else if (mul_done) begin
                        issued_q <= 1'b0;
                        base_q   <= mul_p;
                        idx_q    <= nxt_idx;
                        if (exp_q[nxt_idx]) begin
                            state_q <= S_MUL;
                        end else if (nxt_idx == LAST) begin
                            result_q <= acc_q;
                            state_q  <= S_DONE;
                        end else begin
                            state_q <= S_SQR;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_crypt_engine.sv
// Self-checking bench for rsa_crypt_engine: directed vectors, RSA round-trip,
// rejects, mid-operation disturbance, reset abort and random keys checked against
// a plain-arithmetic modexp model.
module tb_rsa_crypt_engine;

    localparam int BW = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          key_valid = 1'b0;
    logic [BW-1:0] n = '0, e = '0, d = '0, msg = '0;
    logic          start = 1'b0, mode = 1'b0;
    logic          ready, busy, result_valid, err;
    logic [BW-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rsa_crypt_engine dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .n            (n),
        .e            (e),
        .d            (d),
        .start        (start),
        .mode         (mode),
        .msg          (msg),
        .ready        (ready),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .err          (err)
    );

    // Reference: repeated multiplication, no square-and-multiply structure.
    function automatic int modexp(input int b, input int ex, input int m);
        int r = 1;
        for (int i = 0; i < ex; i++) r = (r * b) % m;
        return r;
    endfunction

    function automatic int latency(input int ex);
        return 1 + ($countones(ex) + BW - 1) * (BW + 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Issues one request and checks outcome cycle, result and flags.
    task automatic do_req(input string tag, input logic m, input int mv, input int exp_res,
                          input int exp_lat, input bit exp_err, input bit disturb);
        int w = 0;
        int got = -1;
        logic [BW-1:0] sv_n = n, sv_e = e;
        while (!ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check({tag, "_ready"}, {31'b0, ready}, 32'd1);
        start = 1'b1; mode = m; msg = mv[BW-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        check({tag, "_rdylow"}, {31'b0, ready}, 32'd0);
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (disturb && k == 5) begin
                n = 7'd77; e = 7'd5; key_valid = 1'b0; start = 1'b1;
            end
            if (disturb && k == 6) start = 1'b0;
            if (result_valid || err) begin
                got = k;
                break;
            end
        end
        if (disturb) begin
            n = sv_n; e = sv_e; key_valid = 1'b1; start = 1'b0;
        end
        check({tag, "_cycle"}, got, exp_lat);
        check({tag, "_result"}, {25'b0, result}, exp_res);
        check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        check({tag, "_rv"}, {31'b0, result_valid}, {31'b0, !exp_err});
        @(posedge clk); #1;
        check({tag, "_pulse_end"}, {30'b0, result_valid, err}, 32'd0);
        check({tag, "_ready_back"}, {31'b0, ready}, 32'd1);
        check({tag, "_hold"}, {25'b0, result}, exp_res);
    endtask

    initial begin
        int ct, nn, ee, dd, mm, mv, ex;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {27'b0, ready, busy, result_valid, err, |result}, 32'd0);
        reset = 1'b0;
        key_valid = 1'b1;
        n = 7'd55; e = 7'd3; d = 7'd27;

        // Directed vectors
        do_req("enc2", 1'b0, 2, 8, 65, 1'b0, 1'b0);
        do_req("dec8", 1'b1, 8, 2, 81, 1'b0, 1'b0);

        // Round trip over the whole message space of n=55
        for (int m = 0; m < 55; m++) begin
            ct = modexp(m, 3, 55);
            do_req("rt_enc", 1'b0, m, ct, latency(3), 1'b0, 1'b0);
            do_req("rt_dec", 1'b1, ct, m, latency(27), 1'b0, 1'b0);
        end

        n = 7'd15; e = 7'd3;
        do_req("n15_m7", 1'b0, 7, 13, 65, 1'b0, 1'b0);
        do_req("n15_m0", 1'b0, 0, 0, 65, 1'b0, 1'b0);
        do_req("n15_m14", 1'b0, 14, 14, 65, 1'b0, 1'b0);
        e = 7'd0;
        do_req("exp0", 1'b0, 7, 1, 49, 1'b0, 1'b0);

        // Rejects
        n = 7'd55; e = 7'd3;
        do_req("rej_msg", 1'b0, 55, 0, 1, 1'b1, 1'b0);
        n = 7'd1;
        do_req("rej_n1", 1'b0, 0, 0, 1, 1'b1, 1'b0);

        // Inputs changed / key_valid dropped / start pulsed mid-operation
        n = 7'd55; e = 7'd3;
        do_req("disturb", 1'b0, 2, 8, 65, 1'b0, 1'b1);

        // key_valid low blocks acceptance
        key_valid = 1'b0;
        @(posedge clk); #1;
        check("nokey_ready", {31'b0, ready}, 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("nokey_busy", {31'b0, busy}, 32'd0);
        key_valid = 1'b1;

        // Reset at cycle 30 of a request
        while (!ready) begin
            @(posedge clk); #1;
        end
        start = 1'b1; mode = 1'b1; msg = 7'd8;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 29) reset = 1'b1;
        end
        check("abort_outputs", {27'b0, ready, busy, result_valid, err, |result}, 32'd0);
        reset = 1'b0;
        do_req("after_abort", 1'b1, 8, 2, 81, 1'b0, 1'b0);

        // Random keys and messages
        for (int t = 0; t < 24; t++) begin
            nn = $urandom_range(127, 2);
            ee = $urandom_range(127, 0);
            dd = $urandom_range(127, 0);
            mm = $urandom_range(1, 0);
            n = nn[BW-1:0]; e = ee[BW-1:0]; d = dd[BW-1:0];
            ex = mm ? dd : ee;
            if (t % 6 == 5 && nn < 127) begin
                mv = $urandom_range(127, nn);
                do_req("rnd_rej", mm[0], mv, 0, 1, 1'b1, 1'b0);
            end else begin
                mv = $urandom_range(nn - 1, 0);
                do_req("rnd", mm[0], mv, modexp(mv, ex, nn), latency(ex), 1'b0, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
